// File: rtl/dram_load_ctl.sv
// Diagnostic read/write sequencer for the 512x15 IR dispatch RAM; IR lookups always win the port.
// Optional write read-back verify is enabled by defining DRAM_LOAD_VERIFY_EN.
module dram_load_ctl #(
   parameter int ADDR_BITS  = 9,
   parameter int DATA_WIDTH = 15,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [0:ADDR_BITS-1]  req_addr,
   input  logic [0:DATA_WIDTH-1] req_data,
   input  logic                  ir_lookup,
   output logic                  mem_sel_diag,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [0:ADDR_BITS-1]  mem_addr,
   output logic [0:DATA_WIDTH-1] mem_din,
   input  logic [0:DATA_WIDTH-1] mem_dout,
   output logic                  rsp_valid,
   output logic [0:DATA_WIDTH-1] rsp_data,
   output logic                  rsp_err,
   output logic                  busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCESS,
      S_CAPTURE,
`ifdef DRAM_LOAD_VERIFY_EN
      S_VERIFY_RD,
      S_VERIFY_CMP,
`endif
      S_RESP
   } state_t;

   state_t                r_state;
   logic                  r_write;
   logic [0:ADDR_BITS-1]  r_addr;
   logic [0:DATA_WIDTH-1] r_data;
   logic [CNT_W-1:0]      r_cnt;
   logic [0:DATA_WIDTH-1] r_rsp_data;
   logic                  r_rsp_err;

   state_t                w_next_state;
   logic [CNT_W-1:0]      w_cnt_next;
   logic                  w_accept;
   logic                  w_access;
   logic                  w_we;
   logic                  w_rsp_load;
   logic [0:DATA_WIDTH-1] w_rsp_data_next;
   logic                  w_rsp_err_next;
   logic                  w_timed_out;

   // The stall that would bring the counter up to TIMEOUT is the one that aborts.
   assign w_timed_out = (r_cnt == CNT_W'(TIMEOUT - 1));

   always_comb begin
      w_next_state    = r_state;
      w_cnt_next      = r_cnt;
      w_accept        = 1'b0;
      w_access        = 1'b0;
      w_we            = 1'b0;
      w_rsp_load      = 1'b0;
      w_rsp_data_next = r_rsp_data;
      w_rsp_err_next  = r_rsp_err;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_accept     = 1'b1;
               w_cnt_next   = '0;
               w_next_state = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (ir_lookup) begin
               if (w_timed_out) begin
                  w_next_state    = S_RESP;
                  w_rsp_load      = 1'b1;
                  w_rsp_data_next = '0;
                  w_rsp_err_next  = 1'b1;
               end else begin
                  w_cnt_next = r_cnt + CNT_W'(1);
               end
            end else begin
               w_access = 1'b1;
               w_we     = r_write;
               if (r_write) begin
`ifdef DRAM_LOAD_VERIFY_EN
                  w_cnt_next   = '0;
                  w_next_state = S_VERIFY_RD;
`else
                  w_next_state    = S_RESP;
                  w_rsp_load      = 1'b1;
                  w_rsp_data_next = r_data;
                  w_rsp_err_next  = 1'b0;
`endif
               end else begin
                  w_next_state = S_CAPTURE;
               end
            end
         end
         S_CAPTURE: begin
            // Word was read last cycle, so an IR lookup now cannot disturb it.
            w_rsp_load      = 1'b1;
            w_rsp_data_next = mem_dout;
            w_rsp_err_next  = ~^mem_dout;
            w_next_state    = S_RESP;
         end
`ifdef DRAM_LOAD_VERIFY_EN
         S_VERIFY_RD: begin
            if (ir_lookup) begin
               if (w_timed_out) begin
                  w_next_state    = S_RESP;
                  w_rsp_load      = 1'b1;
                  w_rsp_data_next = '0;
                  w_rsp_err_next  = 1'b1;
               end else begin
                  w_cnt_next = r_cnt + CNT_W'(1);
               end
            end else begin
               w_access     = 1'b1;
               w_next_state = S_VERIFY_CMP;
            end
         end
         S_VERIFY_CMP: begin
            w_rsp_load      = 1'b1;
            w_rsp_data_next = mem_dout;
            w_rsp_err_next  = (mem_dout != r_data) | ~^mem_dout;
            w_next_state    = S_RESP;
         end
`endif
         S_RESP: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_write    <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_cnt      <= '0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_data  <= req_data;
         end
         if (w_rsp_load) begin
            r_rsp_data <= w_rsp_data_next;
            r_rsp_err  <= w_rsp_err_next;
         end
      end
   end

   // Port strobes are gated by reset so a reset cycle can never write the RAM.
   assign mem_sel_diag = w_access & ~reset;
   assign mem_en       = w_access & ~reset;
   assign mem_we       = w_we & ~reset;
   assign mem_addr     = r_addr;
   assign mem_din      = r_data;
   assign req_ready    = (r_state == S_IDLE);
   assign rsp_valid    = (r_state == S_RESP);
   assign rsp_data     = r_rsp_data;
   assign rsp_err      = r_rsp_err;
   assign busy         = (r_state != S_IDLE);

endmodule

// File: doc/dram_load_ctl.md
Name: dram_load_ctl

Overview:
Sequences diagnostic access to the 512x15 instruction dispatch RAM (DRAM) that the IR board uses for A/B/J dispatch lookups. It accepts single-word read/write requests from the diagnostic front end and drives the DRAM address, data and write-enable port. The IR's own LOAD_DRAM lookups always have priority. Every read returns the 15-bit word plus an odd-parity check.

Parameters:
ADDR_BITS, 9, DRAM address width (512 words)
DATA_WIDTH, 15, DRAM word width: A[0:2], B[0:2], PAR, J[1:4], J[7:10]
TIMEOUT, 255, cycles a request may stall on ir_lookup before it is aborted with rsp_err

Ports:
clk  input  1  EBOX clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  diagnostic request present
req_ready  output  1  controller can accept; a request transfers when req_valid & req_ready
req_write  input  1  1 = write, 0 = read
req_addr  input  [0:ADDR_BITS-1]  DRAM word address
req_data  input  [0:DATA_WIDTH-1]  write data
ir_lookup  input  1  IR requests the DRAM this cycle (CON.LOAD_DRAM); highest priority
mem_sel_diag  output  1  steers DRAM address mux to this block
mem_en  output  1  DRAM enable
mem_we  output  1  DRAM write enable
mem_addr  output  [0:ADDR_BITS-1]  DRAM address
mem_din  output  [0:DATA_WIDTH-1]  DRAM write data
mem_dout  input  [0:DATA_WIDTH-1]  DRAM read data; one-cycle synchronous read latency
rsp_valid  output  1  one-cycle pulse: response available
rsp_data  output  [0:DATA_WIDTH-1]  read (or verify) data
rsp_err  output  1  qualified by rsp_valid: parity error, verify mismatch or timeout
busy  output  1  state != IDLE

Behaviour:
- Reset values: state IDLE. req_ready=1. mem_sel_diag, mem_en, mem_we and rsp_valid are 0. rsp_data, mem_addr and mem_din are 0. rsp_err=0. Timeout counter is 0.
- mem_en and mem_we are combinational from state, gated by ~ir_lookup & ~reset. No write can occur during a reset cycle.
- State IDLE: req_ready=1. On handshake, latch op/addr/data, clear counter, go to ACCESS.
- State ACCESS: if ir_lookup is high, drive nothing, increment the counter and stay. If the counter reaches TIMEOUT, go to RESP with rsp_err=1 and rsp_data=0.
- Otherwise in ACCESS: mem_sel_diag=1, mem_en=1, mem_we=req_write. A write goes to RESP (or VERIFY_RD, see the optional feature). A read goes to CAPTURE.
- State CAPTURE: register mem_dout into rsp_data. Set err = ~^mem_dout, i.e. the odd-parity rule fails when the word has an even number of ones. Go to RESP.
- State RESP: rsp_valid=1 for exactly one cycle, then return to IDLE. req_ready is 0 in every state except IDLE.
- A write response has rsp_data = the written word and rsp_err=0 (without verify).
- Unstalled latency: read handshake at edge N gives rsp_valid in cycle N+3; write gives rsp_valid in cycle N+2.
- ir_lookup asserted in the same cycle as the handshake: the request is still accepted and then stalls in ACCESS.
- An ir_lookup arriving in CAPTURE does not disturb the capture, because the data is already presented.
- Reset mid-operation: the request is dropped, no response is issued, and the state is IDLE on the next edge.
- Address 511 and address 0 are ordinary words; addresses do not wrap or auto-increment.

Optional Feature:
DRAM_LOAD_VERIFY_EN.
- Defined: after a write, the controller enters VERIFY_RD. It re-reads the same address, subject to the same ir_lookup stall and timeout rules, then goes to VERIFY_CMP. VERIFY_CMP registers mem_dout into rsp_data and sets rsp_err = (mem_dout != written data) | even parity. Write latency becomes N+4 unstalled.
- Undefined: VERIFY_RD and VERIFY_CMP do not exist and a write completes as described in Behaviour.

Test Plan:
- Write addr 0o254 data 15'o12345, then read 0o254 -> read rsp_valid 3 cycles after its handshake; rsp_data=15'o12345; rsp_err=0 (odd ones count).
- Preload addr 0 with 15'o00003 (even parity), read addr 0 -> rsp_data=15'o00003, rsp_err=1.
- Read addr 0o777 with ir_lookup held high 5 cycles from the handshake -> mem_en stays low for those 5 cycles; rsp_valid in cycle N+8; data correct.
- ir_lookup held high for TIMEOUT cycles -> rsp_valid with rsp_err=1 and rsp_data=0; no mem_we pulse at any point.
- Assert reset in the ACCESS cycle of a write -> mem_we stays 0, memory is unchanged, no rsp_valid, req_ready=1 after the edge.
- With DRAM_LOAD_VERIFY_EN, force mem_dout to differ from the written word -> rsp_err=1 at N+4. Without the macro, the same write -> rsp_err=0 at N+2.
